// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: clocked pipeline stage register with valid/ready handshake,
// stall, flush (bubble insertion) and an optional 2-entry skid buffer.
//
// Parameters:
//   DATA_W    payload width in bits
//   SKID      1: 2-entry skid buffer, in_ready registered
//             0: single entry, in_ready combinational
//   NOP_VALUE payload shown on o_out_data whenever o_out_valid is low
//
// Ports:
//   i_clk        rising-edge clock
//   i_reset      asynchronous active-low reset
//   i_in_valid   upstream payload valid
//   o_in_ready   stage can accept a payload this cycle
//   i_in_data    upstream payload
//   o_out_valid  stage holds a valid payload
//   i_out_ready  downstream accepts this cycle
//   o_out_data   head payload, or NOP_VALUE when empty
//   i_stall      hazard hold; freezes the stage
//   i_flush      synchronous kill of all held payloads (overrides stall)
//   o_occupancy  number of valid entries held (0..2)
module pipe_stage_hs #(
    parameter int unsigned       DATA_W    = 64,
    parameter int unsigned       SKID      = 1,
    parameter logic [DATA_W-1:0] NOP_VALUE = '0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    input  logic              i_stall,
    input  logic              i_flush,
    output logic [1:0]        o_occupancy
);

    logic              r_main_valid;
    logic              r_skid_valid;
    logic              r_in_ready;
    logic [DATA_W-1:0] r_main_data;
    logic [DATA_W-1:0] r_skid_data;

    logic              w_main_valid_d;
    logic              w_skid_valid_d;
    logic [DATA_W-1:0] w_main_data_d;
    logic [DATA_W-1:0] w_skid_data_d;

    logic              w_eff_out_ready;
    logic              w_accept;
    logic              w_emit;

    assign w_eff_out_ready = i_out_ready & ~i_stall;

    // With the skid buffer, in_ready only depends on state (skid empty), so it
    // is taken from a flop; without it, a full stage can still accept when the
    // head leaves in the same cycle.
    assign o_in_ready = (SKID != 0) ? r_in_ready
                                    : (~i_stall & (~r_main_valid | i_out_ready));

    assign w_accept = i_in_valid & o_in_ready & ~i_stall & ~i_flush;
    assign w_emit   = r_main_valid & w_eff_out_ready & ~i_flush;

    always_comb begin
        w_main_valid_d = r_main_valid;
        w_skid_valid_d = r_skid_valid;
        w_main_data_d  = r_main_data;
        w_skid_data_d  = r_skid_data;

        if (i_flush) begin
            w_main_valid_d = 1'b0;
            w_skid_valid_d = 1'b0;
        end else if (SKID != 0) begin
            if (w_emit) begin
                if (r_skid_valid) begin
                    // Skid is full, so in_ready is low and no accept can coincide.
                    w_main_data_d  = r_skid_data;
                    w_skid_valid_d = 1'b0;
                end else if (w_accept) begin
                    w_main_data_d = i_in_data;
                end else begin
                    w_main_valid_d = 1'b0;
                end
            end else if (w_accept) begin
                if (r_main_valid) begin
                    w_skid_valid_d = 1'b1;
                    w_skid_data_d  = i_in_data;
                end else begin
                    w_main_valid_d = 1'b1;
                    w_main_data_d  = i_in_data;
                end
            end
        end else begin
            if (w_accept) begin
                w_main_valid_d = 1'b1;
                w_main_data_d  = i_in_data;
            end else if (w_emit) begin
                w_main_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main_data  <= NOP_VALUE;
            r_skid_data  <= NOP_VALUE;
            r_in_ready   <= 1'b1;
        end else begin
            r_main_valid <= w_main_valid_d;
            r_skid_valid <= w_skid_valid_d;
            r_main_data  <= w_main_data_d;
            r_skid_data  <= w_skid_data_d;
            r_in_ready   <= ~w_skid_valid_d;
        end
    end

    assign o_out_valid = r_main_valid;
    assign o_out_data  = r_main_valid ? r_main_data : NOP_VALUE;
    assign o_occupancy = {1'b0, r_main_valid} + {1'b0, r_skid_valid};

    a_skid_implies_main : assert property (
        @(posedge i_clk) disable iff (!i_reset) r_skid_valid |-> r_main_valid);

    a_out_valid_known : assert property (
        @(posedge i_clk) disable iff (!i_reset) !$isunknown(o_out_valid));

    if (SKID == 0) begin : g_noskid_chk
        a_occ_max_one : assert property (
            @(posedge i_clk) disable iff (!i_reset) o_occupancy <= 2'd1);
    end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// tb_pipe_stage_hs: self-checking bench for pipe_stage_hs.
// Two instances run side by side: u_skid (SKID=1, NOP=0) and u_noskid
// (SKID=0, non-zero NOP). Each is compared every cycle against a queue model:
// the queue holds the payloads in the stage, head first.
module tb_pipe_stage_hs;

    localparam logic [63:0] NOP1 = 64'h0;
    localparam logic [63:0] NOP0 = 64'hBAD0_BAD0_0000_0001;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        v1, or1, st1, fl1;
    logic [63:0] d1;
    logic        ir1, ov1;
    logic [63:0] od1;
    logic [1:0]  occ1;

    logic        v0, or0, st0, fl0;
    logic [63:0] d0;
    logic        ir0, ov0;
    logic [63:0] od0;
    logic [1:0]  occ0;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] q1[$];
    logic [63:0] q0[$];
    bit          acc1, acc0;

    always #5 clk = ~clk;

    pipe_stage_hs #(.DATA_W(64), .SKID(1), .NOP_VALUE(NOP1)) u_skid (
        .i_clk(clk), .i_reset(rst_n),
        .i_in_valid(v1), .o_in_ready(ir1), .i_in_data(d1),
        .o_out_valid(ov1), .i_out_ready(or1), .o_out_data(od1),
        .i_stall(st1), .i_flush(fl1), .o_occupancy(occ1)
    );

    pipe_stage_hs #(.DATA_W(64), .SKID(0), .NOP_VALUE(NOP0)) u_noskid (
        .i_clk(clk), .i_reset(rst_n),
        .i_in_valid(v0), .o_in_ready(ir0), .i_in_data(d0),
        .o_out_valid(ov0), .i_out_ready(or0), .o_out_data(od0),
        .i_stall(st0), .i_flush(fl0), .o_occupancy(occ0)
    );

    // Skid stage: ready whenever fewer than two payloads are held.
    function automatic bit exp_rdy1();
        return q1.size() < 2;
    endfunction

    // Single-entry stage: ready when not stalled and empty or head leaving.
    function automatic bit exp_rdy0();
        return !st0 && (q0.size() == 0 || or0);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("skid_out_valid", 64'(ov1), 64'(q1.size() != 0));
        chk("skid_out_data", od1, (q1.size() != 0) ? q1[0] : NOP1);
        chk("skid_occupancy", 64'(occ1), 64'(q1.size()));
        chk("skid_in_ready", 64'(ir1), 64'(exp_rdy1()));
        chk("noskid_out_valid", 64'(ov0), 64'(q0.size() != 0));
        chk("noskid_out_data", od0, (q0.size() != 0) ? q0[0] : NOP0);
        chk("noskid_occupancy", 64'(occ0), 64'(q0.size()));
        chk("noskid_in_ready", 64'(ir0), 64'(exp_rdy0()));
    endtask

    // Apply the coming rising edge to the model.
    task automatic update_model();
        bit a;
        bit e;
        acc1 = 1'b0;
        acc0 = 1'b0;
        if (rst_n) begin
            if (fl1) begin
                q1.delete();
            end else begin
                a = v1 && exp_rdy1() && !st1;
                e = (q1.size() != 0) && or1 && !st1;
                if (e) void'(q1.pop_front());
                if (a) q1.push_back(d1);
                acc1 = a;
            end
            if (fl0) begin
                q0.delete();
            end else begin
                a = v0 && exp_rdy0() && !st0;
                e = (q0.size() != 0) && or0 && !st0;
                if (e) void'(q0.pop_front());
                if (a) q0.push_back(d0);
                acc0 = a;
            end
        end
    endtask

    // Inputs are driven just after a falling edge; outputs are checked 1 ns
    // later, then the model steps across the rising edge.
    task automatic step();
        #1;
        check_all();
        update_model();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        v1 = 1'b1; d1 = 64'hDEAD; or1 = 1'b0; st1 = 1'b0; fl1 = 1'b0;
        v0 = 1'b0; d0 = 64'h0;    or0 = 1'b0; st0 = 1'b0; fl0 = 1'b0;

        // Reset held with a payload offered: nothing may be taken.
        @(negedge clk);
        step();
        step();
        rst_n = 1'b1;
        step();                       // first edge after release accepts DEAD
        v1 = 1'b0; or1 = 1'b1;
        step();                       // DEAD visible, then emitted
        step();

        // Streaming 1..8 at full throughput.
        for (int i = 1; i <= 8; i++) begin
            v1 = 1'b1; d1 = 64'(i);
            step();
        end
        v1 = 1'b0;
        step();
        step();

        // Backpressure: A to main, B to skid, C held upstream.
        or1 = 1'b0; v1 = 1'b1;
        d1 = 64'hA; step();
        d1 = 64'hB; step();
        d1 = 64'hC; step();
        step();
        or1 = 1'b1;
        acc1 = 1'b0;
        for (int k = 0; k < 6 && !acc1; k++) step();
        v1 = 1'b0;
        step(); step(); step();

        // Stall with a held payload; offered data must not enter.
        or1 = 1'b0; v1 = 1'b1; d1 = 64'h1234;
        step();
        d1 = 64'h5555; or1 = 1'b1; st1 = 1'b1;
        step(); step(); step();
        st1 = 1'b0; v1 = 1'b0;
        step(); step();

        // Flush while full with a payload offered.
        or1 = 1'b0; v1 = 1'b1;
        d1 = 64'hF1; step();
        d1 = 64'hF2; step();
        d1 = 64'hF3; fl1 = 1'b1; step();
        fl1 = 1'b0; v1 = 1'b0; or1 = 1'b1;
        step(); step();

        // Flush together with stall: flush wins.
        or1 = 1'b0; v1 = 1'b1; d1 = 64'hF4;
        step();
        v1 = 1'b0; st1 = 1'b1; fl1 = 1'b1; or1 = 1'b1;
        step();
        st1 = 1'b0; fl1 = 1'b0;
        step();

        // Single-entry stage, out_ready toggling, constant in_valid.
        v0 = 1'b1; d0 = 64'd100; or0 = 1'b0;
        for (int k = 0; k < 24; k++) begin
            or0 = ~or0;
            step();
            if (acc0) d0 = d0 + 64'd1;
        end
        v0 = 1'b0; or0 = 1'b1;
        step(); step();

        // Asynchronous reset in the middle of a transfer.
        v1 = 1'b1; or1 = 1'b0; d1 = 64'h71; step();
        d1 = 64'h72; step();
        v0 = 1'b1; d0 = 64'h77; step();
        #2;
        rst_n = 1'b0;
        q1.delete();
        q0.delete();
        #1;
        check_all();
        @(posedge clk);
        @(negedge clk);
        v1 = 1'b0; v0 = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // Randomised traffic on both stages.
        for (int n = 0; n < 400; n++) begin
            v1  = ($urandom_range(0, 3) != 0);
            d1  = {$urandom(), $urandom()};
            or1 = ($urandom_range(0, 2) != 0);
            st1 = ($urandom_range(0, 9) == 0);
            fl1 = ($urandom_range(0, 19) == 0);
            v0  = ($urandom_range(0, 3) != 0);
            d0  = {$urandom(), $urandom()};
            or0 = ($urandom_range(0, 2) != 0);
            st0 = ($urandom_range(0, 9) == 0);
            fl0 = ($urandom_range(0, 19) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_hs.md
Name: pipe_stage_hs

Overview:
- Parametrised, clocked pipeline stage register; next generation of the IF/ID latch.
- Carries an arbitrary-width payload (e.g. {instruction, pc_plus4}) between two pipeline stages.
- Adds valid/ready handshaking, stall, flush with bubble (NOP) insertion, and an optional 2-entry skid buffer so in_ready is a pure register output.
- Instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB.

Parameters:
- DATA_W, 64, payload width in bits (≥1).
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- NOP_VALUE, 64'h0, payload value driven on out_data while out_valid=0 and after flush (bubble); width DATA_W.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  stage can accept a payload this cycle.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  stage holds a valid payload.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  DATA_W  head payload, or NOP_VALUE when out_valid=0.
- stall  input  1  hazard-unit hold; freezes the stage.
- flush  input  1  synchronous kill of all held payloads.
- occupancy  output  2  number of valid entries held (0..2; max 1 when SKID=0).

Behaviour:
- Reset (reset=0, asynchronous, immediate):
  - main_valid=0, skid_valid=0.
  - out_valid=0, out_data=NOP_VALUE, occupancy=0.
  - in_ready=1 when SKID=1; in_ready=1 combinationally when SKID=0 (stage empty).
- Reset deassertion: takes effect at the first rising clk edge after reset=1; no transfer occurs while reset=0.
- Transfers:
  - Accept: in_valid & in_ready & ~stall & ~flush at a rising edge.
  - Emit: out_valid & out_ready & ~stall & ~flush.
- Effective ready: eff_out_ready = out_ready & ~stall.
- Latency: an accepted payload is visible on out_data/out_valid the cycle after acceptance (1 cycle) when the stage was empty.
- SKID=0:
  - in_ready = ~stall & (~main_valid | out_ready).
  - Accept with simultaneous emit replaces main in the same edge, giving full throughput.
- SKID=1:
  - in_ready = ~skid_valid, registered.
  - Accept while main_valid & ~eff_out_ready: payload goes to skid; in_ready drops next cycle.
  - Emit while skid_valid: skid moves to main, skid clears, in_ready rises next cycle.
  - Accept & emit with skid empty: new payload goes to main.
  - Order is strictly FIFO; no payload is lost or duplicated.
- Stall=1: no accept, no emit, all state held; out_valid and out_data stay stable (no bubble).
- Flush=1 (highest priority, overrides stall):
  - Next edge: main_valid=0, skid_valid=0; an in_data offered the same cycle is dropped.
  - Downstream observing out_valid&out_ready in the flush cycle has not completed a transfer; the source must not count it.
- Bubble: out_data equals NOP_VALUE whenever out_valid=0; it never shows stale payload.
- Occupancy: main_valid + skid_valid. The skid entry is never valid without main_valid.
- Stability: while out_valid=1 and ~eff_out_ready, out_data must not change (AXI-style hold).
- Reset asserted mid-transfer: all entries are discarded immediately, same as reset values.
- Assertions:
  - skid_valid → main_valid.
  - SKID=0 → occupancy ≤ 1.
  - No X on out_valid after reset.

Test Plan:
- Reset with in_valid=1, in_data=64'hDEAD → out_valid=0, out_data=0, occupancy=0; after release, first edge accepts; out_data=64'hDEAD one cycle later.
- Stream 8 payloads 1..8 with out_ready=1, SKID=1 → 8 outputs in order on consecutive cycles, in_ready constantly 1, occupancy=1.
- Backpressure: SKID=1, send A, B, C with out_ready=0 → A in main, B in skid, in_ready=0 and C held upstream; raise out_ready → A, B, C emitted in order, no loss.
- Stall=1 for 3 cycles with out_valid=1 holding 64'h1234 and out_ready=1 → out_data stays 64'h1234, no emit, no accept; release → emits once.
- Flush with occupancy=2 and in_valid=1 → next cycle occupancy=0, out_valid=0, out_data=NOP_VALUE; offered payload not seen later. Flush together with stall → flush wins.
- SKID=0, out_ready toggling 1/0 each cycle with constant in_valid=1 → in_ready mirrors out_ready whenever the stage is full; sequence order preserved; occupancy never exceeds 1.
